// File: rtl/sprot_seq_chk.sv
// sprot_seq_chk: checks start-then-ordered-step handshakes, reports pass/fail per transfer
// Ports: clk, rst_n (sync, active-low); i_start, i_step[NUM_STEPS], i_abort;
//   o_busy, o_xfer_end, o_prot_err, o_err_step, o_xfer_cnt, o_err_cnt.
// Define SPROT_SEQ_CHK_ERR_CNT_EN to build the saturating error counter; otherwise o_err_cnt is 0.
module sprot_seq_chk #(
  parameter int NUM_STEPS = 2,
  parameter int MAX_WAIT = 0,
  parameter int CNT_W = 8,
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [NUM_STEPS-1:0] i_step,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_xfer_end,
  output logic                 o_prot_err,
  output logic [STEP_W-1:0]    o_err_step,
  output logic [CNT_W-1:0]     o_xfer_cnt,
  output logic [CNT_W-1:0]     o_err_cnt
);
  localparam int WCNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  typedef enum logic {S_IDLE, S_STEP} state_t;
  state_t r_state, w_state_nxt;
  logic [STEP_W-1:0] r_idx, w_idx_nxt, r_err_step;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [NUM_STEPS-1:0] w_sel;
  logic w_hit, w_other, w_last, w_tmo, w_act, w_pass, w_fail, w_adv;
  logic r_xfer_end, r_prot_err;
  logic [CNT_W-1:0] r_xfer_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_wcnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idx_nxt;
      r_wcnt <= w_wcnt_nxt;
    end
  end
  always_comb begin
    w_sel = NUM_STEPS'(1) << r_idx;
    w_hit = |(i_step & w_sel);
    w_other = |(i_step & ~w_sel);
    w_last = r_idx == STEP_W'(NUM_STEPS - 1);
    w_tmo = r_wcnt == WCNT_W'(MAX_WAIT);
    w_act = (r_state == S_STEP) && !i_abort;
    // extra or out-of-order bits outrank a correct step
    w_fail = w_act && (w_other || (!w_hit && w_tmo));
    w_pass = w_act && !w_other && w_hit && w_last;
    w_adv = w_act && !w_other && w_hit && !w_last;
    w_state_nxt = (r_state == S_IDLE) ? (i_start ? S_STEP : S_IDLE)
                : ((i_abort || w_fail || w_pass) ? S_IDLE : S_STEP);
    w_idx_nxt = (r_state == S_IDLE) ? '0 : w_adv ? r_idx + 1'b1 : r_idx;
    w_wcnt_nxt = (r_state == S_IDLE || w_adv) ? '0
               : (w_act && i_step == '0 && !w_tmo) ? r_wcnt + 1'b1 : r_wcnt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xfer_end <= 1'b0;
      r_prot_err <= 1'b0;
      r_err_step <= '0;
      r_xfer_cnt <= '0;
    end else begin
      r_xfer_end <= w_pass || w_fail;
      r_prot_err <= w_fail;
      r_err_step <= w_fail ? r_idx : '0;
      if (w_pass && !(&r_xfer_cnt)) r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end
`ifdef SPROT_SEQ_CHK_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (w_fail && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
  end
  assign o_err_cnt = r_err_cnt;
`else
  assign o_err_cnt = '0;
`endif
  assign o_busy = r_state == S_STEP;
  assign o_xfer_end = r_xfer_end;
  assign o_prot_err = r_prot_err;
  assign o_err_step = r_err_step;
  assign o_xfer_cnt = r_xfer_cnt;
endmodule

// File: tb/tb_sprot_seq_chk.sv
// tb_sprot_seq_chk: table, directed and random checks of sprot_seq_chk in three configurations
module tb_sprot_seq_chk;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] stp = '0;
  logic busy0, end0, err0, busy1, end1, err1, busy2, end2, err2;
  logic [0:0] es0, es2;
  logic [1:0] es1;
  logic [7:0] xc0, ec0, xc1, ec1;
  logic [1:0] xc2, ec2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  sprot_seq_chk #(.NUM_STEPS(2), .MAX_WAIT(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_step(stp[1:0]), .i_abort(abort),
    .o_busy(busy0), .o_xfer_end(end0), .o_prot_err(err0), .o_err_step(es0),
    .o_xfer_cnt(xc0), .o_err_cnt(ec0));
  sprot_seq_chk #(.NUM_STEPS(4), .MAX_WAIT(3), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_step(stp), .i_abort(abort),
    .o_busy(busy1), .o_xfer_end(end1), .o_prot_err(err1), .o_err_step(es1),
    .o_xfer_cnt(xc1), .o_err_cnt(ec1));
  sprot_seq_chk #(.NUM_STEPS(2), .MAX_WAIT(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_step(stp[1:0]), .i_abort(abort),
    .o_busy(busy2), .o_xfer_end(end2), .o_prot_err(err2), .o_err_step(es2),
    .o_xfer_cnt(xc2), .o_err_cnt(ec2));
  typedef struct packed {bit act; int idx; int wt; int xc; int ec; bit xe; bit pe; int es;} mst_t;
  typedef struct packed {bit rn; bit st; bit [3:0] sp; bit ab; bit busy; bit xe; bit pe; bit es;} vec_t;
  mst_t m0 = '0, m1 = '0, m2 = '0;
  vec_t tbl[18];
  function automatic mst_t mstep(mst_t s, bit rn, bit st, bit [3:0] sp, bit ab, int ns, int mw, int cw);
    mst_t n;
    int m, top;
    n = s;
    n.xe = 0;
    n.pe = 0;
    n.es = 0;
    top = (1 << cw) - 1;
    m = int'(sp) & ((1 << ns) - 1);
    if (!rn) n = '0;
    else if (!s.act) begin
      if (st) begin
        n.act = 1;
        n.idx = 0;
        n.wt = 0;
      end
    end else if (ab) n.act = 0;
    else if ((m & ~(1 << s.idx)) != 0 || (m == 0 && s.wt == mw)) begin
      n.act = 0;
      n.xe = 1;
      n.pe = 1;
      n.es = s.idx;
`ifdef SPROT_SEQ_CHK_ERR_CNT_EN
      if (s.ec < top) n.ec = s.ec + 1;
`endif
    end else if (m != 0) begin
      if (s.idx == ns - 1) begin
        n.act = 0;
        n.xe = 1;
        if (s.xc < top) n.xc = s.xc + 1;
      end else begin
        n.idx = s.idx + 1;
        n.wt = 0;
      end
    end else n.wt = s.wt + 1;
    return n;
  endfunction
  task automatic cmp(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk(string p, bit b, bit e, bit r, int es, int xc, int ec, mst_t m);
    cmp({p, "_busy"}, b, m.act);
    cmp({p, "_xfer_end"}, e, m.xe);
    cmp({p, "_prot_err"}, r, m.pe);
    cmp({p, "_err_step"}, es, m.es);
    cmp({p, "_xfer_cnt"}, xc, m.xc);
    cmp({p, "_err_cnt"}, ec, m.ec);
  endtask
  task automatic cyc(bit rn, bit st, bit [3:0] sp, bit ab);
    rst_n = rn;
    start = st;
    stp = sp;
    abort = ab;
    @(posedge clk);
    m0 = mstep(m0, rn, st, sp, ab, 2, 0, 8);
    m1 = mstep(m1, rn, st, sp, ab, 4, 3, 8);
    m2 = mstep(m2, rn, st, sp, ab, 2, 0, 2);
    #1;
    chk("u0", busy0, end0, err0, int'(es0), int'(xc0), int'(ec0), m0);
    chk("u1", busy1, end1, err1, int'(es1), int'(xc1), int'(ec1), m1);
    chk("u2", busy2, end2, err2, int'(es2), int'(xc2), int'(ec2), m2);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 4'b0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 4'b0001, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 4'b0010, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 4'b0000, 0, 0, 1, 1, 0};
    tbl[6]  = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 4'b0010, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 0, 4'b0001, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 4'b0011, 0, 0, 1, 1, 1};
    tbl[11] = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[12] = '{1, 0, 4'b0001, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[14] = '{1, 1, 4'b0001, 0, 1, 0, 0, 0};
    tbl[15] = '{1, 1, 4'b0010, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 1, 4'b0000, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 0, 4'b0001, 0, 0, 0, 0, 0};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].rn, tbl[i].st, tbl[i].sp, tbl[i].ab);
      cmp($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
      cmp($sformatf("tbl%0d_xfer_end", i), end0, tbl[i].xe);
      cmp($sformatf("tbl%0d_prot_err", i), err0, tbl[i].pe);
      cmp($sformatf("tbl%0d_err_step", i), es0, tbl[i].es);
    end
    cmp("rst_xfer_cnt", xc0, 0);
    cyc(1, 1, 4'b0000, 0);
    cyc(1, 0, 4'b0001, 0);
    repeat (3) cyc(1, 0, 4'b0000, 0);
    cmp("t4_late_busy", busy1, 1);
    cyc(1, 0, 4'b0010, 0);
    cyc(1, 0, 4'b0100, 0);
    cyc(1, 0, 4'b1000, 0);
    cmp("t4_pass_end", end1, 1);
    cmp("t4_pass_err", err1, 0);
    cmp("t4_pass_cnt", xc1, 1);
    cyc(1, 1, 4'b0000, 0);
    cyc(1, 0, 4'b0001, 0);
    repeat (3) cyc(1, 0, 4'b0000, 0);
    cmp("t4_wait_busy", busy1, 1);
    cyc(1, 0, 4'b0000, 0);
    cmp("t4_tmo_end", end1, 1);
    cmp("t4_tmo_err", err1, 1);
    cmp("t4_tmo_step", es1, 1);
    cyc(0, 0, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 4'b0000, 0);
      cmp($sformatf("t6_accept%0d", i), busy2, 1);
      cyc(1, 0, 4'b0001, 0);
      cyc(1, 0, 4'b0010, 0);
      cmp($sformatf("t6_pass%0d", i), end2, 1);
    end
    cmp("t6_sat_cnt", xc2, 3);
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit [3:0] sp;
      r = $urandom_range(0, 9);
      sp = r < 4 ? 4'b0000 : r < 6 ? 4'(1 << m1.idx) : r < 9 ? 4'(1 << m0.idx) : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, sp, $urandom_range(0, 19) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
